// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage in-order MIPS-subset processor (IF, ID, EX, MEM, WB).
// Holds the PC, instruction memory, register file, ALU, data memory, forwarding
// and hazard/flush logic. State is visible hierarchically through the named
// blocks PC, Instruction_Memory, Registers, Data_Memory and Hazard_Detection_Unit.
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset (PC and pipeline only)
//   start_i - run enable; while low, PC and pipeline registers hold
module pipelined_cpu #(
   parameter int unsigned IMEM_WORDS = 256,
   parameter int unsigned DMEM_BYTES = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i
);
   localparam int unsigned IAW = $clog2(IMEM_WORDS);
   localparam int unsigned DAW = $clog2(DMEM_BYTES);

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_MUL = 3'd4;

   // IF
   logic [31:0] w_pc, w_pc4, w_pc_next, w_instr_if;
   logic [31:0] r_ifid_instr, r_ifid_pc4;
   // ID
   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_imm_ext, w_rf_a, w_rf_b, w_id_a, w_id_b;
   logic        w_reg_write, w_mem_read, w_mem_write, w_alu_src, w_reg_dst, w_is_beq, w_is_j;
   logic [2:0]  w_alu_op;
   logic        w_stall, w_take_beq, w_take_j, w_flush, w_ex_fwd_ok;
   logic        r_idex_reg_write, r_idex_mem_read, r_idex_mem_write, r_idex_alu_src;
   logic [2:0]  r_idex_alu_op;
   logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dest;
   logic [31:0] r_idex_a, r_idex_b, r_idex_imm;
   // EX
   logic [31:0] w_ex_a, w_ex_b_reg, w_ex_b, w_alu;
   logic        r_exmem_reg_write, r_exmem_mem_read, r_exmem_mem_write;
   logic [4:0]  r_exmem_dest;
   logic [31:0] r_exmem_alu, r_exmem_store;
   // MEM / WB
   logic [DAW-3:0] w_dm_word;
   logic [31:0]    w_dm_rdata, w_mem_val;
   logic           r_memwb_reg_write;
   logic [4:0]     r_memwb_dest;
   logic [31:0]    r_memwb_data;
   logic           w_wb_en;

   // ---------------- IF ----------------
   assign w_pc       = PC.pc_o;
   assign w_pc4      = w_pc + 32'd4;
   assign w_instr_if = Instruction_Memory.memory[w_pc[IAW+1:2]];
   assign w_flush    = w_take_j | w_take_beq;

   // A load-use stall wins over any redirect; the branch resolves next cycle.
   always_comb begin
      w_pc_next = w_pc;
      if (start_i && !w_stall) begin
         if (w_take_j)        w_pc_next = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
         else if (w_take_beq) w_pc_next = r_ifid_pc4 + {w_imm_ext[29:0], 2'b00};
         else                 w_pc_next = w_pc4;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ifid_instr <= '0;
         r_ifid_pc4   <= '0;
      end else if (start_i && !w_stall) begin
         r_ifid_instr <= w_flush ? 32'd0 : w_instr_if;
         r_ifid_pc4   <= w_pc4;
      end
   end

   // ---------------- ID ----------------
   assign w_op      = r_ifid_instr[31:26];
   assign w_rs      = r_ifid_instr[25:21];
   assign w_rt      = r_ifid_instr[20:16];
   assign w_rd      = r_ifid_instr[15:11];
   assign w_funct   = r_ifid_instr[5:0];
   assign w_imm_ext = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

   always_comb begin
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_alu_src   = 1'b0;
      w_reg_dst   = 1'b0;
      w_is_beq    = 1'b0;
      w_is_j      = 1'b0;
      w_alu_op    = ALU_ADD;
      case (w_op)
         6'h00: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            case (w_funct)
               6'h20:   w_alu_op = ALU_ADD;
               6'h22:   w_alu_op = ALU_SUB;
               6'h24:   w_alu_op = ALU_AND;
               6'h25:   w_alu_op = ALU_OR;
               6'h18:   w_alu_op = ALU_MUL;
               default: w_reg_write = 1'b0;  // unknown funct, incl. all-zero: NOP
            endcase
         end
         6'h08: begin w_reg_write = 1'b1; w_alu_src = 1'b1; end
         6'h23: begin w_reg_write = 1'b1; w_mem_read = 1'b1; w_alu_src = 1'b1; end
         6'h2B: begin w_mem_write = 1'b1; w_alu_src = 1'b1; end
         6'h04: w_is_beq = 1'b1;
         6'h02: w_is_j   = 1'b1;
         default: ;
      endcase
   end

   // Register read with same-cycle WB bypass (write-first-half, read-second-half).
   assign w_wb_en = start_i && r_memwb_reg_write && (r_memwb_dest != 5'd0);
   assign w_rf_a  = (w_rs == 5'd0) ? 32'd0 :
                    (w_wb_en && r_memwb_dest == w_rs) ? r_memwb_data : Registers.register[w_rs];
   assign w_rf_b  = (w_rt == 5'd0) ? 32'd0 :
                    (w_wb_en && r_memwb_dest == w_rt) ? r_memwb_data : Registers.register[w_rt];

   // beq operands: newest producer first (EX ALU, then MEM stage value).
   // A load still in EX is covered by the stall instead.
   assign w_ex_fwd_ok = r_idex_reg_write && !r_idex_mem_read;
   assign w_id_a = (w_rs == 5'd0) ? 32'd0 :
                   (w_ex_fwd_ok && r_idex_dest == w_rs) ? w_alu :
                   (r_exmem_reg_write && r_exmem_dest == w_rs) ? w_mem_val : w_rf_a;
   assign w_id_b = (w_rt == 5'd0) ? 32'd0 :
                   (w_ex_fwd_ok && r_idex_dest == w_rt) ? w_alu :
                   (r_exmem_reg_write && r_exmem_dest == w_rt) ? w_mem_val : w_rf_b;
   assign w_take_beq = w_is_beq && (w_id_a == w_id_b);
   assign w_take_j   = w_is_j;
   assign w_stall    = Hazard_Detection_Unit.stall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_idex_reg_write <= 1'b0;
         r_idex_mem_read  <= 1'b0;
         r_idex_mem_write <= 1'b0;
         r_idex_alu_src   <= 1'b0;
         r_idex_alu_op    <= ALU_ADD;
         r_idex_rs        <= '0;
         r_idex_rt        <= '0;
         r_idex_dest      <= '0;
         r_idex_a         <= '0;
         r_idex_b         <= '0;
         r_idex_imm       <= '0;
      end else if (start_i) begin
         // Stall turns the ID/EX slot into a bubble by dropping its side effects.
         r_idex_reg_write <= w_reg_write & ~w_stall;
         r_idex_mem_read  <= w_mem_read & ~w_stall;
         r_idex_mem_write <= w_mem_write & ~w_stall;
         r_idex_alu_src   <= w_alu_src;
         r_idex_alu_op    <= w_alu_op;
         r_idex_rs        <= w_rs;
         r_idex_rt        <= w_rt;
         r_idex_dest      <= w_reg_dst ? w_rd : w_rt;
         r_idex_a         <= w_rf_a;
         r_idex_b         <= w_rf_b;
         r_idex_imm       <= w_imm_ext;
      end
   end

   // ---------------- EX ----------------
   always_comb begin
      w_ex_a = r_idex_a;
      if (r_exmem_reg_write && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rs)
         w_ex_a = w_mem_val;
      else if (r_memwb_reg_write && r_memwb_dest != 5'd0 && r_memwb_dest == r_idex_rs)
         w_ex_a = r_memwb_data;
      w_ex_b_reg = r_idex_b;
      if (r_exmem_reg_write && r_exmem_dest != 5'd0 && r_exmem_dest == r_idex_rt)
         w_ex_b_reg = w_mem_val;
      else if (r_memwb_reg_write && r_memwb_dest != 5'd0 && r_memwb_dest == r_idex_rt)
         w_ex_b_reg = r_memwb_data;
   end
   assign w_ex_b = r_idex_alu_src ? r_idex_imm : w_ex_b_reg;

   always_comb begin
      case (r_idex_alu_op)
         ALU_SUB: w_alu = w_ex_a - w_ex_b;
         ALU_AND: w_alu = w_ex_a & w_ex_b;
         ALU_OR:  w_alu = w_ex_a | w_ex_b;
         ALU_MUL: w_alu = w_ex_a * w_ex_b;  // low word is sign-agnostic
         default: w_alu = w_ex_a + w_ex_b;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_exmem_reg_write <= 1'b0;
         r_exmem_mem_read  <= 1'b0;
         r_exmem_mem_write <= 1'b0;
         r_exmem_dest      <= '0;
         r_exmem_alu       <= '0;
         r_exmem_store     <= '0;
      end else if (start_i) begin
         r_exmem_reg_write <= r_idex_reg_write;
         r_exmem_mem_read  <= r_idex_mem_read;
         r_exmem_mem_write <= r_idex_mem_write;
         r_exmem_dest      <= r_idex_dest;
         r_exmem_alu       <= w_alu;
         r_exmem_store     <= w_ex_b_reg;
      end
   end

   // ---------------- MEM ----------------
   assign w_dm_word  = r_exmem_alu[DAW-1:2];
   assign w_dm_rdata = {Data_Memory.memory[{w_dm_word, 2'd3}], Data_Memory.memory[{w_dm_word, 2'd2}],
                        Data_Memory.memory[{w_dm_word, 2'd1}], Data_Memory.memory[{w_dm_word, 2'd0}]};
   assign w_mem_val  = r_exmem_mem_read ? w_dm_rdata : r_exmem_alu;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_memwb_reg_write <= 1'b0;
         r_memwb_dest      <= '0;
         r_memwb_data      <= '0;
      end else if (start_i) begin
         r_memwb_reg_write <= r_exmem_reg_write;
         r_memwb_dest      <= r_exmem_dest;
         r_memwb_data      <= w_mem_val;
      end
   end

   // ---------------- Named state blocks ----------------
   if (1'b1) begin : PC
      logic [31:0] pc_o;
      always_ff @(posedge clk_i) begin
         if (rst_i) pc_o <= '0;
         else       pc_o <= w_pc_next;
      end
   end

   // Preloaded by the environment; never written by the core.
   if (1'b1) begin : Instruction_Memory
      logic [31:0] memory [0:IMEM_WORDS-1];
   end

   if (1'b1) begin : Registers
      logic [31:0] register [0:31];
      always_ff @(posedge clk_i) begin
         if (!rst_i && w_wb_en) register[r_memwb_dest] <= r_memwb_data;
      end
   end

   if (1'b1) begin : Data_Memory
      logic [7:0] memory [0:DMEM_BYTES-1];
      always_ff @(posedge clk_i) begin
         if (!rst_i && start_i && r_exmem_mem_write) begin
            memory[{w_dm_word, 2'd0}] <= r_exmem_store[7:0];
            memory[{w_dm_word, 2'd1}] <= r_exmem_store[15:8];
            memory[{w_dm_word, 2'd2}] <= r_exmem_store[23:16];
            memory[{w_dm_word, 2'd3}] <= r_exmem_store[31:24];
         end
      end
   end

   if (1'b1) begin : Hazard_Detection_Unit
      logic stall;
      assign stall = r_idex_mem_read && ((r_idex_dest == w_rs) || (r_idex_dest == w_rt));
   end
endmodule

// File: tb/tb_pipelined_cpu.sv
module tb_pipelined_cpu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b1;

   pipelined_cpu dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   stall_cnt = 0;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   task automatic push(input logic [4:0] rd, input logic [31:0] val);
      exp_t e;
      e.rd  = rd;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   // Monitor: every register-file write must match the next expected one.
   always @(negedge clk) begin
      if (!rst && start && dut.r_memwb_reg_write && dut.r_memwb_dest != 5'd0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: r%0d <= 0x%0h, no write expected",
                     dut.r_memwb_dest, dut.r_memwb_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (dut.r_memwb_dest !== e.rd || dut.r_memwb_data !== e.val) begin
               n_fail++;
               $display("FAIL wb_write: got r%0d <= 0x%0h want r%0d <= 0x%0h",
                        dut.r_memwb_dest, dut.r_memwb_data, e.rd, e.val);
            end
         end
      end
      if (!rst && start && dut.Hazard_Detection_Unit.stall) stall_cnt++;
   end

   task automatic begin_test();
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      stall_cnt = 0;
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
      for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'hAA;
      for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic end_test(input string name);
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      // ---- 1: reset state and ALU ops ----
      begin_test();
      check("rst_pc", dut.PC.pc_o, 32'd0);
      check("rst_stall", {31'd0, dut.Hazard_Detection_Unit.stall}, 32'd0);
      check("rst_ifid", dut.r_ifid_instr, 32'd0);
      dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
      dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd3);
      dut.Instruction_Memory.memory[2] = enc_r(6'h20, 5'd10, 5'd8, 5'd9);
      dut.Instruction_Memory.memory[3] = enc_r(6'h22, 5'd11, 5'd8, 5'd9);
      dut.Instruction_Memory.memory[4] = enc_r(6'h18, 5'd12, 5'd8, 5'd9);
      push(5'd8, 32'd5);
      push(5'd9, 32'd3);
      push(5'd10, 32'd8);
      push(5'd11, 32'd2);
      push(5'd12, 32'd15);
      rst = 1'b0;
      run(14);
      end_test("t1");
      check("t1_r10", dut.Registers.register[10], 32'd8);
      check("t1_r11", dut.Registers.register[11], 32'd2);
      check("t1_r12", dut.Registers.register[12], 32'd15);
      check("t1_stalls", stall_cnt, 0);

      // ---- 2: back-to-back forwarding ----
      begin_test();
      dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd7);
      dut.Instruction_Memory.memory[1] = enc_r(6'h20, 5'd9, 5'd8, 5'd8);
      push(5'd8, 32'd7);
      push(5'd9, 32'd14);
      rst = 1'b0;
      run(10);
      end_test("t2");
      check("t2_r9", dut.Registers.register[9], 32'd14);
      check("t2_stalls", stall_cnt, 0);

      // ---- 3: load-use ----
      begin_test();
      dut.Data_Memory.memory[0] = 8'd5;
      dut.Data_Memory.memory[1] = 8'd0;
      dut.Data_Memory.memory[2] = 8'd0;
      dut.Data_Memory.memory[3] = 8'd0;
      dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
      dut.Instruction_Memory.memory[1] = enc_r(6'h20, 5'd9, 5'd8, 5'd8);
      push(5'd8, 32'd5);
      push(5'd9, 32'd10);
      rst = 1'b0;
      run(10);
      end_test("t3");
      check("t3_r9", dut.Registers.register[9], 32'd10);
      check("t3_stalls", stall_cnt, 1);

      // ---- 4: store/load round trip, forwarded store data ----
      begin_test();
      dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd300);
      dut.Instruction_Memory.memory[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'd4);
      dut.Instruction_Memory.memory[2] = enc_i(6'h23, 5'd0, 5'd9, 16'd4);
      push(5'd8, 32'd300);
      push(5'd9, 32'd300);
      rst = 1'b0;
      run(10);
      end_test("t4");
      check("t4_m4", {24'd0, dut.Data_Memory.memory[4]}, 32'h2C);
      check("t4_m5", {24'd0, dut.Data_Memory.memory[5]}, 32'h01);
      check("t4_m6", {24'd0, dut.Data_Memory.memory[6]}, 32'h00);
      check("t4_m7", {24'd0, dut.Data_Memory.memory[7]}, 32'h00);
      check("t4_m3", {24'd0, dut.Data_Memory.memory[3]}, 32'hAA);

      // ---- 5: beq taken ----
      begin_test();
      dut.Registers.register[8] = 32'd6;
      dut.Registers.register[9] = 32'd6;
      dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd8, 5'd9, 16'd2);
      dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd10, 16'd1);
      dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd11, 16'd2);
      dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd12, 16'd3);
      push(5'd12, 32'd3);
      rst = 1'b0;
      run(2);
      check("t5_pc_target", dut.PC.pc_o, 32'd12);
      check("t5_flushed", dut.r_ifid_instr, 32'd0);
      run(1);
      check("t5_pc_next", dut.PC.pc_o, 32'd16);
      run(8);
      end_test("t5");
      check("t5_r10", dut.Registers.register[10], 32'd0);
      check("t5_r12", dut.Registers.register[12], 32'd3);

      // ---- 6: j, start_i low, r0 ----
      begin_test();
      dut.Instruction_Memory.memory[0] = {6'h02, 26'd8};
      dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd10, 16'd1);
      dut.Instruction_Memory.memory[8] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      dut.Instruction_Memory.memory[9] = enc_i(6'h08, 5'd0, 5'd11, 16'd4);
      push(5'd11, 32'd4);
      rst = 1'b0;
      run(2);
      check("t6_pc_target", dut.PC.pc_o, 32'h20);
      check("t6_flushed", dut.r_ifid_instr, 32'd0);
      run(1);
      check("t6_pc_pre_hold", dut.PC.pc_o, 32'h24);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run(1);
         check("t6_pc_hold", dut.PC.pc_o, 32'h24);
      end
      start = 1'b1;
      run(10);
      end_test("t6");
      check("t6_r0", dut.Registers.register[0], 32'd0);
      check("t6_r10", dut.Registers.register[10], 32'd0);
      check("t6_r11", dut.Registers.register[11], 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
